// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI memory responder.
// Build option: AXI_MEM_RANGE_CHECK_EN enables out-of-window SLVERR responses.
package axi_mem_responder_pkg;

  localparam int unsigned AXI_ADDR_W = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4
  } state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mem_axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } mem_axi_rsp_t;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Next-beat address for an AXI burst; WRAP is handled as INCR.
module axi_mem_addr_gen
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = AXI_ADDR_W
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] next_addr
);

  logic [AddrWidth-1:0] step_s;
  logic [AddrWidth-1:0] aligned_s;

  // Align to the beat size, then advance by one beat unless the burst is FIXED.
  always_comb begin
    step_s    = AddrWidth'(1) << size;
    aligned_s = addr & ~(step_s - AddrWidth'(1));
    next_addr = aligned_s + step_s;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = aligned_s + step_s;
      BURST_WRAP:  next_addr = aligned_s + step_s;
      default:     next_addr = aligned_s + step_s;
    endcase
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate serving one transaction at a time from a single-port memory.
// Build option: AXI_MEM_RANGE_CHECK_EN returns SLVERR for addresses beyond the memory window.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = AXI_ADDR_W,
  parameter int unsigned AxiDataWidth = AXI_DATA_W,
  parameter int unsigned AxiIdWidth   = AXI_ID_W,
  parameter int unsigned MemAddrWidth = 16,
  parameter type         axi_req_t    = mem_axi_req_t,
  parameter type         axi_rsp_t    = mem_axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  axi_req_t                  axi_req_i,
  output axi_rsp_t                  axi_resp_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [AxiDataWidth-1:0]   mem_wdata_o,
  output logic [AxiDataWidth/8-1:0] mem_be_o,
  input  logic [AxiDataWidth-1:0]   mem_rdata_i,
  output logic                      busy_o
);

  localparam int unsigned OffW = $clog2(AxiDataWidth / 8);

  state_e                  state_r;
  state_e                  state_s;
  logic [AxiIdWidth-1:0]   id_r;
  logic [AxiAddrWidth-1:0] addr_r;
  logic [7:0]              len_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic [7:0]              cnt_r;
  logic [AxiDataWidth-1:0] rdata_r;
  logic                    rd_first_r;
  logic                    wr_prio_r;

  logic                    aw_grant_s;
  logic                    ar_grant_s;
  logic                    last_beat_s;
  logic                    range_err_s;
  logic [AxiAddrWidth-1:0] next_addr_s;

  // Round-robin pointer only matters when both address channels are valid.
  assign aw_grant_s  = (state_r == ST_IDLE) && axi_req_i.aw_valid &&
                       (!axi_req_i.ar_valid || wr_prio_r);
  assign ar_grant_s  = (state_r == ST_IDLE) && axi_req_i.ar_valid &&
                       (!axi_req_i.aw_valid || !wr_prio_r);
  assign last_beat_s = (cnt_r == len_r);
  assign mem_addr_o  = addr_r[MemAddrWidth+OffW-1:OffW];

  axi_mem_addr_gen #(
    .AddrWidth (AxiAddrWidth)
  ) u_addr_gen (
    .addr      (addr_r),
    .size      (size_r),
    .burst     (burst_r),
    .next_addr (next_addr_s)
  );

`ifdef AXI_MEM_RANGE_CHECK_EN
  logic                    range_err_r;
  logic [AxiAddrWidth-1:0] grant_addr_s;

  assign grant_addr_s = aw_grant_s ? axi_req_i.aw.addr : axi_req_i.ar.addr;
  assign range_err_s  = range_err_r;

  // Out-of-window flag is fixed for the whole burst at address acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      range_err_r <= 1'b0;
    end else if (aw_grant_s || ar_grant_s) begin
      range_err_r <= |grant_addr_s[AxiAddrWidth-1:MemAddrWidth+OffW];
    end
  end
`else
  assign range_err_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a burst ends on len even if w.last disagrees.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_grant_s) begin
          state_s = ST_WR_DATA;
        end else if (ar_grant_s) begin
          state_s = ST_RD_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        if (axi_req_i.w_valid && last_beat_s) begin
          state_s = ST_WR_RESP;
        end else begin
          state_s = ST_WR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (axi_req_i.b_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WR_RESP;
        end
      end
      ST_RD_REQ: state_s = ST_RD_DATA;
      ST_RD_DATA: begin
        if (axi_req_i.r_ready && last_beat_s) begin
          state_s = ST_IDLE;
        end else if (axi_req_i.r_ready) begin
          state_s = ST_RD_REQ;
        end else begin
          state_s = ST_RD_DATA;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; read data bypasses the holding register on the first RD_DATA cycle.
  always_comb begin
    axi_resp_o      = '0;
    axi_resp_o.b.id = id_r;
    axi_resp_o.r.id = id_r;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_wdata_o     = '0;
    mem_be_o        = '0;
    busy_o          = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        axi_resp_o.aw_ready = aw_grant_s;
        axi_resp_o.ar_ready = ar_grant_s;
      end
      ST_WR_DATA: begin
        axi_resp_o.w_ready = 1'b1;
        mem_req_o          = axi_req_i.w_valid && !range_err_s;
        mem_we_o           = 1'b1;
        mem_wdata_o        = axi_req_i.w.data;
        mem_be_o           = axi_req_i.w.strb;
      end
      ST_WR_RESP: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.resp  = range_err_s ? RESP_SLVERR : RESP_OKAY;
      end
      ST_RD_REQ: begin
        mem_req_o = !range_err_s;
        mem_we_o  = 1'b0;
      end
      ST_RD_DATA: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.data  = range_err_s ? '0 : (rd_first_r ? mem_rdata_i : rdata_r);
        axi_resp_o.r.resp  = range_err_s ? RESP_SLVERR : RESP_OKAY;
        axi_resp_o.r.last  = last_beat_s;
      end
      default: begin
        axi_resp_o = '0;
      end
    endcase
  end

  // Transaction context, beat counter, read holding register and arbitration pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_r       <= '0;
      addr_r     <= '0;
      len_r      <= 8'd0;
      size_r     <= 3'd0;
      burst_r    <= 2'd0;
      cnt_r      <= 8'd0;
      rdata_r    <= '0;
      rd_first_r <= 1'b0;
      wr_prio_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (aw_grant_s) begin
            id_r      <= axi_req_i.aw.id;
            addr_r    <= axi_req_i.aw.addr;
            len_r     <= axi_req_i.aw.len;
            size_r    <= axi_req_i.aw.size;
            burst_r   <= axi_req_i.aw.burst;
            cnt_r     <= 8'd0;
            wr_prio_r <= 1'b0;
          end else if (ar_grant_s) begin
            id_r      <= axi_req_i.ar.id;
            addr_r    <= axi_req_i.ar.addr;
            len_r     <= axi_req_i.ar.len;
            size_r    <= axi_req_i.ar.size;
            burst_r   <= axi_req_i.ar.burst;
            cnt_r     <= 8'd0;
            wr_prio_r <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (axi_req_i.w_valid) begin
            cnt_r  <= cnt_r + 8'd1;
            addr_r <= next_addr_s;
          end
        end
        ST_RD_REQ: begin
          rd_first_r <= 1'b1;
        end
        ST_RD_DATA: begin
          if (rd_first_r) begin
            rdata_r    <= mem_rdata_i;
            rd_first_r <= 1'b0;
          end
          if (axi_req_i.r_ready) begin
            cnt_r  <= cnt_r + 8'd1;
            addr_r <= next_addr_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected B/R/memory traffic queued at stimulus time.
module tb_axi_mem_responder;
  import axi_mem_responder_pkg::*;

  localparam bit RANGE_CHK =
`ifdef AXI_MEM_RANGE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  mem_axi_req_t req;
  mem_axi_rsp_t rsp;
  logic         mem_req, mem_we, busy;
  logic [15:0]  mem_addr;
  logic [63:0]  mem_wdata, mem_rdata;
  logic [7:0]   mem_be;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (rsp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } exp_b_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } exp_r_t;
  typedef struct { logic we; logic [15:0] addr; logic [63:0] data; logic [7:0] be; } exp_m_t;

  exp_b_t exp_b[$];
  exp_r_t exp_r[$];
  exp_m_t exp_m[$];

  int checks   = 0;
  int failures = 0;
  int r_beats  = 0;

  logic [63:0] mem     [0:65535];
  logic [63:0] ref_mem [0:65535];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                        input logic [7:0] be);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  function automatic bit addr_oob(input logic [63:0] a);
    return RANGE_CHK && (|a[63:19]);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Single-port memory model with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_be);
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Monitor: compares every B/R handshake and memory access against the queues.
  always @(negedge clk) begin
    exp_b_t eb;
    exp_r_t er;
    exp_m_t em;
    if (rst_n) begin
      if (rsp.b_valid && req.b_ready) begin
        if (exp_b.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b.pop_front();
          check_eq("b_id", 64'(rsp.b.id), 64'(eb.id));
          check_eq("b_resp", 64'(rsp.b.resp), 64'(eb.resp));
        end
      end
      if (rsp.r_valid && req.r_ready) begin
        r_beats++;
        if (exp_r.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_r.pop_front();
          check_eq("r_id", 64'(rsp.r.id), 64'(er.id));
          check_eq("r_data", rsp.r.data, er.data);
          check_eq("r_resp", 64'(rsp.r.resp), 64'(er.resp));
          check_eq("r_last", 64'(rsp.r.last), 64'(er.last));
        end
      end
      if (mem_req) begin
        if (exp_m.size() == 0) check_eq("mem_unexpected", 64'd1, 64'd0);
        else begin
          em = exp_m.pop_front();
          check_eq("mem_we", 64'(mem_we), 64'(em.we));
          check_eq("mem_addr", 64'(mem_addr), 64'(em.addr));
          if (em.we) begin
            check_eq("mem_wdata", mem_wdata, em.data);
            check_eq("mem_be", 64'(mem_be), 64'(em.be));
          end
        end
      end
    end
  end

  // sel: 0 AW handshake, 1 W handshake, 2 AR handshake, 3 B handshake, 4 r_valid.
  task automatic wait_hs(input int sel, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = req.aw_valid && rsp.aw_ready;
        1: hit = req.w_valid && rsp.w_ready;
        2: hit = req.ar_valid && rsp.ar_ready;
        3: hit = req.b_ready && rsp.b_valid;
        4: hit = rsp.r_valid;
        default: hit = 1'b1;
      endcase
    end
    if (!hit) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [63:0] data0, input logic [7:0] strb, input bit early_last);
    logic [63:0] a;
    bit          oob;
    oob = addr_oob(addr);
    exp_b.push_back('{id, oob ? RESP_SLVERR : RESP_OKAY});
    req.aw = '{id: id, addr: addr, len: len, size: 3'd3, burst: BURST_INCR};
    req.aw_valid = 1'b1;
    wait_hs(0, "aw");
    req.aw_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 64'(b) * 64'd8;
      if (!oob) begin
        exp_m.push_back('{1'b1, a[18:3], data0 + 64'(b), strb});
        ref_mem[a[18:3]] = merge(ref_mem[a[18:3]], data0 + 64'(b), strb);
      end
      req.w = '{data: data0 + 64'(b), strb: strb, last: early_last ? (b == 0) : (b == int'(len))};
      req.w_valid = 1'b1;
      wait_hs(1, "w");
    end
    req.w_valid = 1'b0;
    check_eq("b_latency", 64'(rsp.b_valid), 64'd1);
    req.b_ready = 1'b1;
    wait_hs(3, "b");
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall);
    logic [63:0] a, d0;
    bit          oob;
    int          start;
    oob = addr_oob(addr);
    d0  = 64'd0;
    for (int b = 0; b <= int'(len); b++) begin
      a = (burst == BURST_FIXED) ? addr : addr + 64'(b) * 64'd8;
      exp_r.push_back('{id, oob ? 64'd0 : ref_mem[a[18:3]], oob ? RESP_SLVERR : RESP_OKAY,
                        b == int'(len)});
      if (b == 0) d0 = oob ? 64'd0 : ref_mem[a[18:3]];
      if (!oob) exp_m.push_back('{1'b0, a[18:3], 64'd0, 8'd0});
    end
    start = r_beats;
    req.ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
    req.ar_valid = 1'b1;
    wait_hs(2, "ar");
    req.ar_valid = 1'b0;
    if (stall > 0) begin
      req.r_ready = 1'b0;
      wait_hs(4, "r_valid");
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check_eq("stall_rdata", rsp.r.data, d0);
        check_eq("stall_memreq", 64'(mem_req), 64'd0);
        check_eq("stall_busy", 64'(busy), 64'd1);
      end
      @(posedge clk); #1;
    end
    req.r_ready = 1'b1;
    for (int i = 0; i < 200 && (r_beats - start) < int'(len) + 1; i++) @(posedge clk);
    #1;
    check_eq("r_beat_count", 64'(r_beats - start), 64'(int'(len) + 1));
    req.r_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 64'hA5A5_0000_0000_0000 | 64'(i);
      ref_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_memreq", 64'(mem_req), 64'd0);
    check_eq("rst_valids", 64'({rsp.b_valid, rsp.r_valid, rsp.w_ready}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin: both valid twice; AW wins first, AR second.
    exp_m.push_back('{1'b1, 16'h0060, 64'h0123_4567_89AB_CDEF, 8'hFF});
    ref_mem[16'h0060] = 64'h0123_4567_89AB_CDEF;
    exp_b.push_back('{4'd1, RESP_OKAY});
    exp_r.push_back('{4'd2, ref_mem[16'h0060], RESP_OKAY, 1'b1});
    exp_m.push_back('{1'b0, 16'h0060, 64'd0, 8'd0});
    exp_m.push_back('{1'b1, 16'h0061, 64'h7777_0000_1111_2222, 8'hFF});
    ref_mem[16'h0061] = 64'h7777_0000_1111_2222;
    exp_b.push_back('{4'd3, RESP_OKAY});
    req.aw = '{id: 4'd1, addr: 64'h300, len: 8'd0, size: 3'd3, burst: BURST_INCR};
    req.ar = '{id: 4'd2, addr: 64'h300, len: 8'd0, size: 3'd3, burst: BURST_INCR};
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    @(negedge clk);
    check_eq("rr1_aw_ready", 64'(rsp.aw_ready), 64'd1);
    check_eq("rr1_ar_ready", 64'(rsp.ar_ready), 64'd0);
    @(posedge clk); #1;
    req.aw = '{id: 4'd3, addr: 64'h308, len: 8'd0, size: 3'd3, burst: BURST_INCR};
    req.w  = '{data: 64'h0123_4567_89AB_CDEF, strb: 8'hFF, last: 1'b1};
    req.w_valid = 1'b1;
    req.b_ready = 1'b1;
    wait_hs(1, "rr_w1");
    req.w_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rr2_ar_ready", 64'(rsp.ar_ready), 64'd1);
    check_eq("rr2_aw_ready", 64'(rsp.aw_ready), 64'd0);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    req.r_ready  = 1'b1;
    wait_hs(0, "rr_aw2");
    req.aw_valid = 1'b0;
    req.w = '{data: 64'h7777_0000_1111_2222, strb: 8'hFF, last: 1'b1};
    req.w_valid = 1'b1;
    wait_hs(1, "rr_w2");
    req.w_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req.b_ready = 1'b0;
    req.r_ready = 1'b0;
    check_eq("rr_queues_empty", 64'(exp_b.size() + exp_r.size()), 64'd0);

    axi_write(4'b1000, 64'h40, 8'd0, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0);
    axi_read (4'b0001, 64'h40, 8'd0, BURST_INCR, 0);
    axi_read (4'b1100, 64'h100, 8'd1, BURST_INCR, 0);
    axi_read (4'b0010, 64'h180, 8'd3, BURST_INCR, 5);
    axi_write(4'b0011, 64'h200, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    axi_write(4'b0100, 64'h200, 8'd0, 64'h0, 8'h0F, 1'b0);
    axi_read (4'b0101, 64'h200, 8'd0, BURST_INCR, 0);
    axi_write(4'b0110, 64'h400, 8'd1, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    axi_read (4'b0111, 64'h400, 8'd1, BURST_FIXED, 0);
    axi_read (4'b1001, 64'h7FFF8, 8'd1, BURST_INCR, 0);
    axi_read (4'b1010, 64'h8_0000, 8'd0, BURST_INCR, 0);
    axi_read (4'b1011, 64'h408, 8'd0, BURST_WRAP, 0);

    repeat (5) @(posedge clk);
    #1;
    check_eq("final_queues_empty", 64'(exp_b.size() + exp_r.size() + exp_m.size()), 64'd0);
    check_eq("final_idle", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
